ld_st_mem_arbiter: RTL and testbench
====================================

# ld_st_mem_arbiter

Sequences the single data-memory port between the load FIFO head and the committed-store head. Grants one access at a time, pops the winning queue, and holds the request until the memory responds. Formats byte/half/word masks and data, and returns load results for CDB broadcast. Sits between the load FIFO / store queue and the D-cache port.

## Interface
- ROB_IDX_W, 5, ROB index width
- PREG_W, 6, physical register address width
- STARVE_LIMIT, 4, consecutive store wins tolerated while a load waits (≥1)

- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- flush  in  1  squash in-flight/pending load
- ld_valid  in  1  load FIFO non-empty and head ready
- ld_addr  in  32  load byte address
- ld_funct3  in  3  LB/LH/LW/LBU/LHU
- ld_pd  in  PREG_W  load destination preg
- ld_rob  in  ROB_IDX_W  load ROB index
- ld_ren  out  1  pop load FIFO
- st_valid  in  1  store head committed
- st_addr  in  32  store byte address
- st_wdata  in  32  store data (low-aligned)
- st_funct3  in  3  SB/SH/SW
- st_ren  out  1  pop store queue
- dmem_addr  out  32  word-aligned address
- dmem_rmask  out  4  read byte mask
- dmem_wmask  out  4  write byte mask
- dmem_wdata  out  32  lane-shifted write data
- dmem_rdata  in  32  read data
- dmem_resp  in  1  access complete
- ld_done  out  1  load result valid
- ld_done_pd  out  PREG_W  result preg
- ld_done_rob  out  ROB_IDX_W  result ROB index
- ld_done_data  out  32  extended load data
- busy  out  1  state ≠ IDLE

## Operation
- FSM: IDLE, LD_WAIT, ST_WAIT, DRAIN. Reset → IDLE. All registered outputs and the starve counter reset to 0.
- IDLE grant rules, evaluated in priority order:
  - A load is eligible when ld_valid && !flush.
  - A conflict exists when st_valid && st_addr[31:2]==ld_addr[31:2]. On conflict the store wins.
  - Otherwise, if the starve counter equals STARVE_LIMIT and a load is eligible, the load wins.
  - Otherwise the store wins if st_valid, else the load if eligible.
- Pop outputs:
  - ld_ren and st_ren are combinational.
  - Each is high only in IDLE for the granted side.
  - At most one is high per cycle.
- On grant:
  - Latch the request fields and drive the dmem_* registers.
  - Next state is LD_WAIT or ST_WAIT.
- Starve counter:
  - Increments, saturating at STARVE_LIMIT, when in IDLE with a load eligible and the store granted.
  - Clears on load grant, and when ld_valid is low in IDLE.
- Masks, with o = addr[1:0]:
  - Byte: 4'b0001<<o.
  - Half: 4'b0011<<{o[1],1'b0} (addr[0] ignored).
  - Word: 4'hF.
- A load drives rmask and wmask=0. A store drives wmask, rmask=0, and wdata=st_wdata<<(8*o).
- dmem_addr={addr[31:2],2'b00}. Address, masks and data are held constant until dmem_resp. Masks are 0 in IDLE.
- LD_WAIT on dmem_resp:
  - Register ld_done=1, ld_done_pd, ld_done_rob.
  - ld_done_data = (rdata>>(8*o)), sign-extended for LB/LH and zero-extended for LBU/LHU.
  - Go to IDLE.
- ST_WAIT on dmem_resp: go to IDLE. Stores are committed, so flush is ignored.
- LD_WAIT with flush: go to DRAIN and keep the request held. DRAIN on dmem_resp goes to IDLE with no ld_done. flush together with dmem_resp in LD_WAIT also suppresses ld_done.
- ld_done is a one-cycle pulse.

## Timing
- Grant/pop in cycle T. dmem masks are valid from T+1. dmem_resp is legal from T+1.
- dmem_resp in cycle R gives ld_done in R+1. The FSM is in IDLE in R+1 and may grant in R+1.
- Minimum spacing is 2 cycles per access. dmem_resp outside LD_WAIT, ST_WAIT or DRAIN is ignored.
- Asynchronous rst mid-access: immediately IDLE, all outputs 0. Any memory response still pending is the memory side's problem.

## Configuration
- LDST_ARB_STATS_EN defined: adds outputs perf_ld_cnt (32), perf_st_cnt (32) and perf_stall_cnt (32).
  - perf_ld_cnt and perf_st_cnt count completed loads/stores, including drained loads.
  - perf_stall_cnt counts cycles with ld_valid high, not in IDLE, or a load eligible but not granted.
  - All wrap modulo 2^32 and reset to 0.
- Undefined: these ports and counters are absent. All other behaviour is identical.

## Test plan
- LB, addr 0x1003, rdata 0x80_00_00_00, resp at T+1:
  - ld_ren@T, rmask 4'b1000.
  - ld_done@T+2 with data 0xFFFFFF80 and the correct pd/rob.
- SH, addr 0x2002, wdata 0x0000BEEF:
  - st_ren, wmask 4'b1100, wdata 0xBEEF0000, dmem_addr 0x2000.
- Conflict: ld 0x3004, st 0x3006 both valid, with the starve counter at STARVE_LIMIT → store granted first, then load.
- Starvation: st_valid and ld_valid held high with distinct words, STARVE_LIMIT=4 → 4 store grants, then 1 load grant, repeating.
- Flush in LD_WAIT, resp 3 cycles later:
  - FSM enters DRAIN with the request held.
  - No ld_done. Next grant occurs the cycle after resp.
- rst asserted in ST_WAIT:
  - busy, masks and ld_done go 0 immediately.
  - After release, a new ld_valid is granted in the first cycle.

Source files
------------

// File: rtl/ld_st_mem_arbiter.sv
// Arbitrates the single D-cache port between the load FIFO head and the committed-store head.
// Optional performance counters are enabled with `define LDST_ARB_STATS_EN.
module ld_st_mem_arbiter #(
    parameter int ROB_IDX_W    = 5,
    parameter int PREG_W       = 6,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 ld_valid,
    input  logic [31:0]          ld_addr,
    input  logic [2:0]           ld_funct3,
    input  logic [PREG_W-1:0]    ld_pd,
    input  logic [ROB_IDX_W-1:0] ld_rob,
    output logic                 ld_ren,
    input  logic                 st_valid,
    input  logic [31:0]          st_addr,
    input  logic [31:0]          st_wdata,
    input  logic [2:0]           st_funct3,
    output logic                 st_ren,
    output logic [31:0]          dmem_addr,
    output logic [3:0]           dmem_rmask,
    output logic [3:0]           dmem_wmask,
    output logic [31:0]          dmem_wdata,
    input  logic [31:0]          dmem_rdata,
    input  logic                 dmem_resp,
    output logic                 ld_done,
    output logic [PREG_W-1:0]    ld_done_pd,
    output logic [ROB_IDX_W-1:0] ld_done_rob,
    output logic [31:0]          ld_done_data,
    output logic                 busy
`ifdef LDST_ARB_STATS_EN
    ,
    output logic [31:0]          perf_ld_cnt,
    output logic [31:0]          perf_st_cnt,
    output logic [31:0]          perf_stall_cnt
`endif
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LD_WAIT = 2'd1,
        S_ST_WAIT = 2'd2,
        S_DRAIN   = 2'd3
    } state_e;

    state_e                 state_q;
    logic [CNT_W-1:0]       starve_q, starve_d;
    logic [2:0]             funct3_q;
    logic [1:0]             off_q;
    logic [PREG_W-1:0]      pd_q;
    logic [ROB_IDX_W-1:0]   rob_q;
    logic [31:0]            dmem_addr_q, dmem_wdata_q, ld_done_data_q;
    logic [3:0]             dmem_rmask_q, dmem_wmask_q;
    logic                   ld_done_q;
    logic [PREG_W-1:0]      ld_done_pd_q;
    logic [ROB_IDX_W-1:0]   ld_done_rob_q;
    logic                   ld_elig_s, conflict_s, grant_ld_s, grant_st_s;

    function automatic logic [3:0] byte_mask(input logic [2:0] f3, input logic [1:0] o);
        logic [3:0] m;
        case (f3[1:0])
            2'b00:   m = 4'b0001 << o;
            2'b01:   m = 4'b0011 << {o[1], 1'b0};
            default: m = 4'hF;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] rdata,
                                                input logic [1:0] o);
        logic [31:0] s;
        logic [31:0] r;
        s = rdata >> {o, 3'b000};
        case (f3)
            3'b000:  r = {{24{s[7]}}, s[7:0]};
            3'b001:  r = {{16{s[15]}}, s[15:0]};
            3'b100:  r = {24'd0, s[7:0]};
            3'b101:  r = {16'd0, s[15:0]};
            default: r = s;
        endcase
        return r;
    endfunction

    assign ld_elig_s  = ld_valid && !flush;
    assign conflict_s = st_valid && (st_addr[31:2] == ld_addr[31:2]);

    // Grant selection in IDLE: same-word conflict, then starvation relief, then stores first.
    always_comb begin
        grant_ld_s = 1'b0;
        grant_st_s = 1'b0;
        if (state_q == S_IDLE) begin
            if (conflict_s) begin
                grant_st_s = 1'b1;
            end else if ((starve_q == STARVE_MAX) && ld_elig_s) begin
                grant_ld_s = 1'b1;
            end else if (st_valid) begin
                grant_st_s = 1'b1;
            end else if (ld_elig_s) begin
                grant_ld_s = 1'b1;
            end else begin
                grant_ld_s = 1'b0;
            end
        end else begin
            grant_ld_s = 1'b0;
        end
    end

    // Starve counter next state: counts store wins over a waiting load.
    always_comb begin
        starve_d = starve_q;
        if (state_q == S_IDLE) begin
            if (grant_ld_s || !ld_valid) begin
                starve_d = '0;
            end else if (ld_elig_s && grant_st_s && (starve_q != STARVE_MAX)) begin
                starve_d = starve_q + CNT_W'(1);
            end else begin
                starve_d = starve_q;
            end
        end else begin
            starve_d = starve_q;
        end
    end

    // Starve counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    // Main FSM with registered memory request and load-completion outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            funct3_q       <= 3'd0;
            off_q          <= 2'd0;
            pd_q           <= '0;
            rob_q          <= '0;
            dmem_addr_q    <= 32'd0;
            dmem_rmask_q   <= 4'd0;
            dmem_wmask_q   <= 4'd0;
            dmem_wdata_q   <= 32'd0;
            ld_done_q      <= 1'b0;
            ld_done_pd_q   <= '0;
            ld_done_rob_q  <= '0;
            ld_done_data_q <= 32'd0;
        end else begin
            ld_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant_ld_s) begin
                        state_q      <= S_LD_WAIT;
                        funct3_q     <= ld_funct3;
                        off_q        <= ld_addr[1:0];
                        pd_q         <= ld_pd;
                        rob_q        <= ld_rob;
                        dmem_addr_q  <= {ld_addr[31:2], 2'b00};
                        dmem_rmask_q <= byte_mask(ld_funct3, ld_addr[1:0]);
                        dmem_wmask_q <= 4'd0;
                        dmem_wdata_q <= 32'd0;
                    end else if (grant_st_s) begin
                        state_q      <= S_ST_WAIT;
                        dmem_addr_q  <= {st_addr[31:2], 2'b00};
                        dmem_rmask_q <= 4'd0;
                        dmem_wmask_q <= byte_mask(st_funct3, st_addr[1:0]);
                        dmem_wdata_q <= st_wdata << {st_addr[1:0], 3'b000};
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_LD_WAIT: begin
                    if (dmem_resp) begin
                        state_q      <= S_IDLE;
                        dmem_addr_q  <= 32'd0;
                        dmem_rmask_q <= 4'd0;
                        if (!flush) begin
                            ld_done_q      <= 1'b1;
                            ld_done_pd_q   <= pd_q;
                            ld_done_rob_q  <= rob_q;
                            ld_done_data_q <= load_extend(funct3_q, dmem_rdata, off_q);
                        end else begin
                            ld_done_q <= 1'b0;
                        end
                    end else if (flush) begin
                        // Request stays on the port; the memory still owes a response.
                        state_q <= S_DRAIN;
                    end else begin
                        state_q <= S_LD_WAIT;
                    end
                end
                S_ST_WAIT, S_DRAIN: begin
                    if (dmem_resp) begin
                        state_q      <= S_IDLE;
                        dmem_addr_q  <= 32'd0;
                        dmem_rmask_q <= 4'd0;
                        dmem_wmask_q <= 4'd0;
                        dmem_wdata_q <= 32'd0;
                    end else begin
                        state_q <= state_q;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ld_ren       = grant_ld_s;
    assign st_ren       = grant_st_s;
    assign dmem_addr    = dmem_addr_q;
    assign dmem_rmask   = dmem_rmask_q;
    assign dmem_wmask   = dmem_wmask_q;
    assign dmem_wdata   = dmem_wdata_q;
    assign ld_done      = ld_done_q;
    assign ld_done_pd   = ld_done_pd_q;
    assign ld_done_rob  = ld_done_rob_q;
    assign ld_done_data = ld_done_data_q;
    assign busy         = (state_q != S_IDLE);

`ifdef LDST_ARB_STATS_EN
    logic [31:0] perf_ld_cnt_q, perf_st_cnt_q, perf_stall_cnt_q;

    // Completion and stall counters; drained loads count as completed loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_ld_cnt_q    <= 32'd0;
            perf_st_cnt_q    <= 32'd0;
            perf_stall_cnt_q <= 32'd0;
        end else begin
            if (dmem_resp && ((state_q == S_LD_WAIT) || (state_q == S_DRAIN))) begin
                perf_ld_cnt_q <= perf_ld_cnt_q + 32'd1;
            end
            if (dmem_resp && (state_q == S_ST_WAIT)) begin
                perf_st_cnt_q <= perf_st_cnt_q + 32'd1;
            end
            if (ld_valid && ((state_q != S_IDLE) || (ld_elig_s && !grant_ld_s))) begin
                perf_stall_cnt_q <= perf_stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_ld_cnt    = perf_ld_cnt_q;
    assign perf_st_cnt    = perf_st_cnt_q;
    assign perf_stall_cnt = perf_stall_cnt_q;
`endif

endmodule

// File: tb/tb_ld_st_mem_arbiter.sv
// Directed self-checking bench for ld_st_mem_arbiter (default parameters, STARVE_LIMIT=4).
module tb_ld_st_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [2:0]  ld_funct3;
    logic [5:0]  ld_pd;
    logic [4:0]  ld_rob;
    logic        ld_ren;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_wdata;
    logic [2:0]  st_funct3;
    logic        st_ren;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        ld_done;
    logic [5:0]  ld_done_pd;
    logic [4:0]  ld_done_rob;
    logic [31:0] ld_done_data;
    logic        busy;
`ifdef LDST_ARB_STATS_EN
    logic [31:0] perf_ld_cnt, perf_st_cnt, perf_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic exp_ld;

    ld_st_mem_arbiter dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_funct3(ld_funct3),
        .ld_pd(ld_pd), .ld_rob(ld_rob), .ld_ren(ld_ren),
        .st_valid(st_valid), .st_addr(st_addr), .st_wdata(st_wdata),
        .st_funct3(st_funct3), .st_ren(st_ren),
        .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .ld_done(ld_done), .ld_done_pd(ld_done_pd), .ld_done_rob(ld_done_rob),
        .ld_done_data(ld_done_data), .busy(busy)
`ifdef LDST_ARB_STATS_EN
        , .perf_ld_cnt(perf_ld_cnt), .perf_st_cnt(perf_st_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; ld_valid = 1'b0; ld_addr = 32'd0; ld_funct3 = 3'd0;
        ld_pd = 6'd0; ld_rob = 5'd0; st_valid = 1'b0; st_addr = 32'd0; st_wdata = 32'd0;
        st_funct3 = 3'd0; dmem_rdata = 32'd0; dmem_resp = 1'b0;
        tick(); tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rmask", {28'd0, dmem_rmask}, 32'd0);
        check("rst_wmask", {28'd0, dmem_wmask}, 32'd0);
        check("rst_ld_done", {31'd0, ld_done}, 32'd0);
        rst = 1'b0;

        // LB at 0x1003, sign-extended byte from lane 3
        ld_addr = 32'h0000_1003; ld_funct3 = 3'b000; ld_pd = 6'd5; ld_rob = 5'd9; ld_valid = 1'b1;
        #1;
        check("lb_ld_ren", {31'd0, ld_ren}, 32'd1);
        check("lb_st_ren", {31'd0, st_ren}, 32'd0);
        tick();
        ld_valid = 1'b0;
        check("lb_rmask", {28'd0, dmem_rmask}, 32'h8);
        check("lb_wmask", {28'd0, dmem_wmask}, 32'h0);
        check("lb_addr", dmem_addr, 32'h0000_1000);
        check("lb_busy", {31'd0, busy}, 32'd1);
        dmem_rdata = 32'h8000_0000; dmem_resp = 1'b1;
        tick();
        dmem_resp = 1'b0;
        check("lb_done", {31'd0, ld_done}, 32'd1);
        check("lb_data", ld_done_data, 32'hFFFF_FF80);
        check("lb_pd", {26'd0, ld_done_pd}, 32'd5);
        check("lb_rob", {27'd0, ld_done_rob}, 32'd9);
        check("lb_rmask_idle", {28'd0, dmem_rmask}, 32'd0);
        tick();
        check("lb_done_pulse", {31'd0, ld_done}, 32'd0);

        // SH at 0x2002
        st_addr = 32'h0000_2002; st_wdata = 32'h0000_BEEF; st_funct3 = 3'b001; st_valid = 1'b1;
        #1;
        check("sh_st_ren", {31'd0, st_ren}, 32'd1);
        check("sh_ld_ren", {31'd0, ld_ren}, 32'd0);
        tick();
        st_valid = 1'b0;
        check("sh_wmask", {28'd0, dmem_wmask}, 32'hC);
        check("sh_rmask", {28'd0, dmem_rmask}, 32'h0);
        check("sh_wdata", dmem_wdata, 32'hBEEF_0000);
        check("sh_addr", dmem_addr, 32'h0000_2000);
        dmem_resp = 1'b1;
        tick();
        dmem_resp = 1'b0;
        check("sh_busy_after", {31'd0, busy}, 32'd0);
        check("sh_wmask_idle", {28'd0, dmem_wmask}, 32'd0);

        // Starvation pattern S S S S L S S S S, then same-word conflict (store), then load
        ld_addr = 32'h0000_4000; ld_funct3 = 3'b010; ld_valid = 1'b1;
        st_addr = 32'h0000_5000; st_funct3 = 3'b010; st_wdata = 32'h1234_5678; st_valid = 1'b1;
        for (int i = 0; i < 11; i++) begin
            if (i == 9) begin
                ld_addr = 32'h0000_3004; st_addr = 32'h0000_3006;
            end
            if (i == 10) begin
                st_valid = 1'b0; ld_funct3 = 3'b001;
            end
            exp_ld = (i == 4) || (i == 10);
            #1;
            check($sformatf("starve_ld_ren_%0d", i), {31'd0, ld_ren}, {31'd0, exp_ld});
            check($sformatf("starve_st_ren_%0d", i), {31'd0, st_ren}, {31'd0, !exp_ld});
            tick();
            if (i == 9) begin
                check("conflict_addr", dmem_addr, 32'h0000_3004);
                check("conflict_wmask", {28'd0, dmem_wmask}, 32'hF);
            end
            dmem_rdata = 32'h0000_8000 + 32'(i); dmem_resp = 1'b1;
            tick();
            dmem_resp = 1'b0;
            if (exp_ld) begin
                check($sformatf("starve_done_%0d", i), {31'd0, ld_done}, 32'd1);
                check($sformatf("starve_data_%0d", i), ld_done_data,
                      (i == 4) ? 32'h0000_8004 : 32'hFFFF_800A);
            end
        end
        ld_valid = 1'b0;

        // Flush in LD_WAIT -> DRAIN, response three cycles after grant
        ld_addr = 32'h0000_6001; ld_funct3 = 3'b100; ld_valid = 1'b1;
        #1;
        check("fl_ld_ren", {31'd0, ld_ren}, 32'd1);
        tick();
        ld_valid = 1'b0; flush = 1'b1;
        #1;
        check("fl_rmask", {28'd0, dmem_rmask}, 32'h2);
        tick();
        flush = 1'b0;
        check("fl_drain_busy", {31'd0, busy}, 32'd1);
        check("fl_drain_rmask", {28'd0, dmem_rmask}, 32'h2);
        check("fl_drain_addr", dmem_addr, 32'h0000_6000);
        tick();
        ld_addr = 32'h0000_7000; ld_funct3 = 3'b010; ld_valid = 1'b1; dmem_resp = 1'b1;
        #1;
        check("fl_drain_no_grant", {31'd0, ld_ren}, 32'd0);
        tick();
        dmem_resp = 1'b0;
        #1;
        check("fl_no_done", {31'd0, ld_done}, 32'd0);
        check("fl_regrant", {31'd0, ld_ren}, 32'd1);
        check("fl_idle", {31'd0, busy}, 32'd0);
        tick();
        ld_valid = 1'b0; flush = 1'b1; dmem_resp = 1'b1;
        tick();
        flush = 1'b0; dmem_resp = 1'b0;
        check("flresp_no_done", {31'd0, ld_done}, 32'd0);
        check("flresp_idle", {31'd0, busy}, 32'd0);
        flush = 1'b1; ld_valid = 1'b1;
        #1;
        check("flush_idle_block", {31'd0, ld_ren}, 32'd0);
        flush = 1'b0; ld_valid = 1'b0;

        // Asynchronous reset during ST_WAIT
        tick();
        st_addr = 32'h0000_8001; st_funct3 = 3'b000; st_wdata = 32'h0000_0055; st_valid = 1'b1;
        #1;
        check("sb_st_ren", {31'd0, st_ren}, 32'd1);
        tick();
        st_valid = 1'b0;
        check("sb_wmask", {28'd0, dmem_wmask}, 32'h2);
        check("sb_wdata", dmem_wdata, 32'h0000_5500);
        check("sb_busy", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_wmask", {28'd0, dmem_wmask}, 32'd0);
        check("arst_rmask", {28'd0, dmem_rmask}, 32'd0);
        check("arst_ld_done", {31'd0, ld_done}, 32'd0);
        tick();
        rst = 1'b0;
        ld_addr = 32'h0000_9000; ld_funct3 = 3'b010; ld_pd = 6'd33; ld_rob = 5'd17; ld_valid = 1'b1;
        #1;
        check("post_rst_ld_ren", {31'd0, ld_ren}, 32'd1);
        tick();
        ld_valid = 1'b0;
        check("post_rst_rmask", {28'd0, dmem_rmask}, 32'hF);
        dmem_rdata = 32'hCAFE_F00D; dmem_resp = 1'b1;
        tick();
        dmem_resp = 1'b0;
        check("post_rst_done", {31'd0, ld_done}, 32'd1);
        check("post_rst_data", ld_done_data, 32'hCAFE_F00D);
        check("post_rst_pd", {26'd0, ld_done_pd}, 32'd33);
        check("post_rst_rob", {27'd0, ld_done_rob}, 32'd17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
